x25519_engine_arbiter: RTL and testbench

X25519_ENGINE_ARBITER -- requirements
Module: x25519_engine_arbiter

---
 rtl/x25519_pkg.sv | 31 +++
 rtl/x25519_rr_arbiter.sv | 32 +++
 rtl/x25519_engine_arbiter.sv | 116 +++++++++++
 tb/tb_x25519_engine_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/x25519_pkg.sv
// Shared definitions for the X25519 engine arbiter: operand widths,
// arbiter FSM states, the accepted-job operand pair and scalar clamping.
package x25519_pkg;

    localparam int X25519_W     = 256;
    localparam int X25519_RES_W = 512;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_t;

    // Operand pair selected from the granted requester.
    typedef struct packed {
        logic [X25519_W-1:0] work;
        logic [X25519_W-1:0] e;
    } x25519_job_t;

    // RFC 7748 scalar clamping: clear the low three bits and bit 255, set bit 254.
    function automatic logic [X25519_W-1:0] clamp_scalar(input logic [X25519_W-1:0] e);
        logic [X25519_W-1:0] r;
        r          = e;
        r[2:0]     = 3'b000;
        r[255]     = 1'b0;
        r[254]     = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/x25519_rr_arbiter.sv
// Round-robin grant selection. Search starts at the index after last_ptr
// and wraps; the first requester found valid receives the one-hot grant.
module x25519_rr_arbiter
    import x25519_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_ptr,
    output logic [NUM_REQ-1:0]         grant
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] idx;
    logic           found;

    // Walk the requesters in priority order from last_ptr+1, keep the first hit.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(last_ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/x25519_engine_arbiter.sv
// Shares one X25519 scalar-multiply engine among NUM_REQ requesters.
// One job is in flight at a time: accept -> ISSUE (start pulse) -> BUSY
// (engine running) -> RESPOND (result held until taken).
// Build option: define X25519_ARB_CLAMP_EN to clamp the scalar at accept.
module x25519_engine_arbiter
    import x25519_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*X25519_W-1:0]   req_work,
    input  logic [NUM_REQ*X25519_W-1:0]   req_e,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [X25519_RES_W-1:0]       resp_work,
    output logic                          eng_en,
    output logic [X25519_W-1:0]           eng_work_in,
    output logic [X25519_W-1:0]           eng_e,
    input  logic                          eng_out_valid,
    input  logic [X25519_RES_W-1:0]       eng_work_out
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t          state;
    logic [IDW-1:0]      last_ptr;
    logic [IDW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0]  grant;
    x25519_job_t         sel_job;
    logic [X25519_W-1:0] acc_e;
    logic                accept;

    x25519_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req      (req_valid),
        .last_ptr (last_ptr),
        .grant    (grant)
    );

    // Grants are only visible while idle; a requester that drops valid simply
    // falls out of the search, so no stale grant can be issued.
    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    // Encode the one-hot grant and select that requester's operand slices.
    always_comb begin
        gnt_idx = '0;
        sel_job = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx      = IDW'(i);
                sel_job.work = req_work[i*X25519_W +: X25519_W];
                sel_job.e    = req_e[i*X25519_W +: X25519_W];
            end
        end
    end

`ifdef X25519_ARB_CLAMP_EN
    assign acc_e = clamp_scalar(sel_job.e);
`else
    assign acc_e = sel_job.e;
`endif

    // Job FSM with registered outputs. Operands only load on accept, so they
    // stay stable for the engine from ISSUE until the response is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_ptr    <= IDW'(NUM_REQ - 1);
            eng_en      <= 1'b0;
            eng_work_in <= '0;
            eng_e       <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_work   <= '0;
        end else begin
            eng_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_ISSUE;
                        eng_en      <= 1'b1;
                        eng_work_in <= sel_job.work;
                        eng_e       <= acc_e;
                        resp_id     <= gnt_idx;
                        last_ptr    <= gnt_idx;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    // Done pulses outside BUSY are ignored by construction.
                    if (eng_out_valid) begin
                        resp_work  <= eng_work_out;
                        resp_valid <= 1'b1;
                        state      <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_x25519_engine_arbiter.sv
// Directed bench for x25519_engine_arbiter with a small fixed-latency engine stub.
module tb_x25519_engine_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ENG_LAT = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*256-1:0]   req_work;
    logic [NUM_REQ*256-1:0]   req_e;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [1:0]               resp_id;
    logic [511:0]             resp_work;
    logic                     eng_en;
    logic [255:0]             eng_work_in;
    logic [255:0]             eng_e;
    logic                     eng_out_valid;
    logic [511:0]             eng_work_out;

    // engine stub state and injection path
    logic                     st_run = 1'b0;
    logic                     st_ov  = 1'b0;
    int                       st_cnt = 0;
    logic [511:0]             st_res = '0;
    logic                     inj_ov;
    logic [511:0]             inj_data;

    int vectors = 0;
    int errs    = 0;
    int overlap = 0;
    int grant_q[$];

    always #5 clk = ~clk;

    x25519_engine_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_work      (req_work),
        .req_e         (req_e),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_work     (resp_work),
        .eng_en        (eng_en),
        .eng_work_in   (eng_work_in),
        .eng_e         (eng_e),
        .eng_out_valid (eng_out_valid),
        .eng_work_out  (eng_work_out)
    );

    function automatic logic [511:0] model(input logic [255:0] w, input logic [255:0] e);
        return {w ^ e, w + e};
    endfunction

    function automatic logic [255:0] exp_e(input logic [255:0] e);
`ifdef X25519_ARB_CLAMP_EN
        return {1'b0, 1'b1, e[253:3], 3'b000};
`else
        return e;
`endif
    endfunction

    assign eng_out_valid = st_ov | inj_ov;
    assign eng_work_out  = inj_ov ? inj_data : st_res;

    // engine stub: fixed latency from start pulse to done pulse, reset with the block
    always @(posedge clk) begin
        if (rst) begin
            st_run <= 1'b0;
            st_ov  <= 1'b0;
            st_cnt <= 0;
        end else begin
            st_ov <= 1'b0;
            if (eng_en) begin
                st_run <= 1'b1;
                st_cnt <= ENG_LAT;
                st_res <= model(eng_work_in, eng_e);
            end else if (st_run) begin
                if (st_cnt == 1) begin
                    st_ov  <= 1'b1;
                    st_run <= 1'b0;
                end else begin
                    st_cnt <= st_cnt - 1;
                end
            end
        end
    end

    // grant log and start-while-busy detector
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
            if (eng_en && st_run) overlap <= overlap + 1;
        end
    end

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_resp_valid"}, 512'(resp_valid), 512'(1));
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        grant_q.delete();
    endtask

    initial begin
        logic [255:0] ones;
        logic [255:0] e_cl;
        ones      = '1;
        rst       = 1'b1;
        req_valid = '0;
        resp_ready = 1'b0;
        req_work  = '0;
        req_e     = '0;
        inj_ov    = 1'b0;
        inj_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_work[i*256 +: 256] = 256'(100 + i);
            req_e[i*256 +: 256]    = 256'(200 + i);
        end
        req_work[2*256 +: 256] = 256'd9;
        req_e[2*256 +: 256]    = 256'd1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 512'(req_ready), 512'(0));
        chk("rst_eng_en", 512'(eng_en), 512'(0));
        chk("rst_resp_valid", 512'(resp_valid), 512'(0));
        chk("rst_resp_id", 512'(resp_id), 512'(0));
        chk("rst_resp_work", resp_work, 512'(0));
        chk("rst_eng_work_in", 512'(eng_work_in), 512'(0));
        chk("rst_eng_e", 512'(eng_e), 512'(0));
        rst = 1'b0;
        grant_q.delete();

        // single request from requester 2
        @(negedge clk);
        req_valid = 4'b0100;
        #1 chk("single_grant", 512'(req_ready), 512'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("single_eng_en", 512'(eng_en), 512'(1));
        chk("single_work_in", 512'(eng_work_in), 512'(9));
        chk("single_eng_e", 512'(eng_e), 512'(exp_e(256'd1)));
        chk("single_busy_ready", 512'(req_ready), 512'(0));
        @(negedge clk);
        chk("single_eng_en_off", 512'(eng_en), 512'(0));
        wait_resp("single");
        chk("single_resp_id", 512'(resp_id), 512'(2));
        chk("single_resp_work", resp_work, model(256'd9, exp_e(256'd1)));
        release_resp();
        chk("single_resp_done", 512'(resp_valid), 512'(0));

        // contention from reset: 0 then 3
        do_reset();
        req_valid = 4'b1001;
        #1 chk("cont_grant0", 512'(req_ready), 512'(4'b0001));
        @(negedge clk);
        req_valid = 4'b1000;
        wait_resp("cont0");
        chk("cont0_id", 512'(resp_id), 512'(0));
        chk("cont0_work", resp_work, model(256'd100, exp_e(256'd200)));
        release_resp();
        #1 chk("cont_grant3", 512'(req_ready), 512'(4'b1000));
        @(negedge clk);
        req_valid = '0;
        wait_resp("cont3");
        chk("cont3_id", 512'(resp_id), 512'(3));
        chk("cont3_work", resp_work, model(256'd103, exp_e(256'd203)));
        release_resp();
        chk("cont_count", 512'(grant_q.size()), 512'(2));
        if (grant_q.size() == 2) begin
            chk("cont_order0", 512'(grant_q[0]), 512'(0));
            chk("cont_order1", 512'(grant_q[1]), 512'(3));
        end
        chk("cont_overlap", 512'(overlap), 512'(0));

        // backpressure on requester 1's response
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        wait_resp("bp");
        chk("bp_id", 512'(resp_id), 512'(1));
        chk("bp_work", resp_work, model(256'd101, exp_e(256'd201)));
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", 512'(resp_valid), 512'(1));
            chk("bp_hold_id", 512'(resp_id), 512'(1));
            chk("bp_hold_work", resp_work, model(256'd101, exp_e(256'd201)));
            chk("bp_hold_ready", 512'(req_ready), 512'(0));
        end
        resp_ready = 1'b1;
        #1 chk("bp_same_cycle_ready", 512'(req_ready), 512'(0));
        @(negedge clk);
        resp_ready = 1'b0;
        #1 chk("bp_next_grant", 512'(req_ready), 512'(4'b0100));
        req_valid = '0;
        #1 chk("withdraw_ready", 512'(req_ready), 512'(0));
        @(negedge clk);
        chk("withdraw_no_issue", 512'(eng_en), 512'(0));

        // reset while BUSY, then a stray done pulse
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        inj_ov   = 1'b1;
        inj_data = {16{32'hDEADBEEF}};
        @(negedge clk);
        inj_ov = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        chk("rstbusy_resp_valid", 512'(resp_valid), 512'(0));
        chk("rstbusy_resp_work", resp_work, 512'(0));
        chk("rstbusy_resp_id", 512'(resp_id), 512'(0));
        chk("rstbusy_eng_en", 512'(eng_en), 512'(0));
        chk("rstbusy_work_in", 512'(eng_work_in), 512'(0));
        chk("rstbusy_eng_e", 512'(eng_e), 512'(0));
        chk("rstbusy_req_ready", 512'(req_ready), 512'(0));
        req_valid = 4'b1111;
        #1 chk("rstbusy_ptr_reset", 512'(req_ready), 512'(4'b0001));
        req_valid = '0;

        // scalar clamping at accept
        req_e[0 +: 256] = ones;
`ifdef X25519_ARB_CLAMP_EN
        e_cl = {1'b0, 1'b1, {251{1'b1}}, 3'b000};
`else
        e_cl = ones;
`endif
        @(negedge clk);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        chk("clamp_eng_e", 512'(eng_e), 512'(e_cl));
        wait_resp("clamp");
        chk("clamp_resp_work", resp_work, model(256'd100, e_cl));
        release_resp();
        req_e[0 +: 256] = 256'd200;

        // fairness: all four held valid for eight jobs
        do_reset();
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int c = 0; c < 300 && grant_q.size() < 8; c++) @(negedge clk);
        req_valid = '0;
        repeat (20) @(negedge clk);
        resp_ready = 1'b0;
        chk("fair_count", 512'(grant_q.size()), 512'(8));
        for (int i = 0; i < 8 && i < grant_q.size(); i++)
            chk($sformatf("fair_order%0d", i), 512'(grant_q[i]), 512'(i % 4));
        chk("fair_overlap", 512'(overlap), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
